pp_pipeline_accel_dim_bcast: RTL and testbench

// - Captures frame dimensions (in/out height and width) once per frame and derives subsampled dimensions and pixel counts.
// - Broadcasts the results to NUM_CONS downstream dataflow processes.
// - Holds the results stable until every consumer has acknowledged. Range-checks dimensions and reports cfg_err.
// - Sits at the head of the pp_pipeline_accel dataflow region; parametrised successor of the fixed dimension-latch entry proc.

---
 rtl/pp_pipeline_accel_pkg.sv | 13 +
 rtl/pp_pipeline_accel_seq_mul.sv | 65 ++++++
 rtl/pp_pipeline_accel_dim_bcast.sv | 161 ++++++++++++++++
 tb/tb_pp_pipeline_accel_dim_bcast.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pipeline_accel_pkg.sv
// Shared types and constants for the pp_pipeline_accel dataflow head.
package pp_pipeline_accel_pkg;

    localparam int unsigned MaxDimDefault = 4096;

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    // Internal dimension width: enough bits to hold max_dim itself.
    function automatic int unsigned calc_nb(input int unsigned max_dim);
        return $clog2(max_dim) + 1;
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_seq_mul.sv
// Shift-add sequential multiplier: W cycles from start to done, product held until next start.
module pp_pipeline_accel_seq_mul #(
    parameter int unsigned W = 13
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;

    // The start edge already performs the first partial product.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            acc_d    = b_i[0] ? {{W{1'b0}}, a_i} : '0;
            mcand_d  = {{W{1'b0}}, a_i} << 1;
            mplier_d = b_i >> 1;
            cnt_d    = CntW'(W - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign done_o    = busy_q && (cnt_q == '0);
    assign product_o = acc_q;

endmodule

// File: rtl/pp_pipeline_accel_dim_bcast.sv
// Captures frame dimensions, derives subsampled sizes and pixel counts, and broadcasts
// them to NUM_CONS consumers, holding results until every consumer has acknowledged.
module pp_pipeline_accel_dim_bcast
    import pp_pipeline_accel_pkg::*;
#(
    parameter int unsigned DIM_W     = 32,
    parameter int unsigned MAX_DIM   = MaxDimDefault,
    parameter int unsigned SUB_SHIFT = 1,
    parameter int unsigned NUM_CONS  = 4,
    parameter int unsigned PIX_W     = 26,
    localparam int unsigned NB       = calc_nb(MAX_DIM)
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_ready,
    output logic                ap_idle,
    output logic                ap_done,
    input  logic [DIM_W-1:0]    in_img_height,
    input  logic [DIM_W-1:0]    in_img_width,
    input  logic [DIM_W-1:0]    out_img_height,
    input  logic [DIM_W-1:0]    out_img_width,
    input  logic [NUM_CONS-1:0] cons_ack,
    output logic [NUM_CONS-1:0] dim_valid,
    output logic [DIM_W-1:0]    in_h,
    output logic [DIM_W-1:0]    in_w,
    output logic [DIM_W-1:0]    out_h,
    output logic [DIM_W-1:0]    out_w,
    output logic [NB-1:0]       sub_h,
    output logic [NB-1:0]       sub_w,
    output logic [PIX_W-1:0]    in_pixels,
    output logic [PIX_W-1:0]    out_pixels,
    output logic                cfg_err
);

    state_e              state_q, state_d;
    logic [NUM_CONS-1:0] valid_q, valid_d;
    logic                capture, dims_bad, mul_start, mul_done, done_in, done_out;
    logic [2*NB-1:0]     prod_in, prod_out;

    logic [DIM_W-1:0] in_h_q, in_w_q, out_h_q, out_w_q;
    logic [NB-1:0]    sub_h_q, sub_w_q;
    logic [PIX_W-1:0] in_pix_q, out_pix_q;
    logic             cfg_err_q;

    function automatic logic dim_bad(input logic [DIM_W-1:0] d);
        return (d == '0) || (d > DIM_W'(MAX_DIM));
    endfunction

    assign dims_bad  = dim_bad(in_img_height) || dim_bad(in_img_width) ||
                       dim_bad(out_img_height) || dim_bad(out_img_width);
    assign capture   = (state_q == StIdle) && ap_start;
    assign mul_start = capture && !dims_bad;
    assign mul_done  = done_in && done_out;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        case (state_q)
            StIdle: begin
                if (ap_start) begin
                    if (dims_bad) begin
                        state_d = StHold;
                        valid_d = '1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (mul_done) begin
                    state_d = StHold;
                    valid_d = '1;
                end
            end
            StHold: begin
                valid_d = valid_q & ~cons_ack;
                if (valid_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Pixel counts keep the previous frame's values until CALC finishes.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in_h_q    <= '0;
            in_w_q    <= '0;
            out_h_q   <= '0;
            out_w_q   <= '0;
            sub_h_q   <= '0;
            sub_w_q   <= '0;
            in_pix_q  <= '0;
            out_pix_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (capture) begin
                in_h_q    <= in_img_height;
                in_w_q    <= in_img_width;
                out_h_q   <= out_img_height;
                out_w_q   <= out_img_width;
                sub_h_q   <= NB'(in_img_height >> SUB_SHIFT);
                sub_w_q   <= NB'(in_img_width >> SUB_SHIFT);
                cfg_err_q <= dims_bad;
                if (dims_bad) begin
                    in_pix_q  <= '0;
                    out_pix_q <= '0;
                end
            end
            if ((state_q == StCalc) && mul_done) begin
                in_pix_q  <= PIX_W'(prod_in);
                out_pix_q <= PIX_W'(prod_out);
            end
        end
    end

    pp_pipeline_accel_seq_mul #(.W(NB)) u_mul_in (
        .clk_i     (ap_clk),
        .rst_ni    (ap_rst_n),
        .start_i   (mul_start),
        .a_i       (NB'(in_img_height)),
        .b_i       (NB'(in_img_width)),
        .done_o    (done_in),
        .product_o (prod_in)
    );

    pp_pipeline_accel_seq_mul #(.W(NB)) u_mul_out (
        .clk_i     (ap_clk),
        .rst_ni    (ap_rst_n),
        .start_i   (mul_start),
        .a_i       (NB'(out_img_height)),
        .b_i       (NB'(out_img_width)),
        .done_o    (done_out),
        .product_o (prod_out)
    );

    assign ap_ready   = capture && ap_rst_n;
    assign ap_idle    = (state_q == StIdle) && !ap_start;
    assign ap_done    = (state_q == StHold);
    assign dim_valid  = valid_q;
    assign in_h       = in_h_q;
    assign in_w       = in_w_q;
    assign out_h      = out_h_q;
    assign out_w      = out_w_q;
    assign sub_h      = sub_h_q;
    assign sub_w      = sub_w_q;
    assign in_pixels  = in_pix_q;
    assign out_pixels = out_pix_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pp_pipeline_accel_dim_bcast.sv
// Scoreboard bench for pp_pipeline_accel_dim_bcast: expectations queued at capture,
// checked when ap_done rises.
module tb_pp_pipeline_accel_dim_bcast;

    localparam int unsigned NB = 13;

    logic        clk, rst_n, ap_start, ap_ready, ap_idle, ap_done, cfg_err;
    logic [31:0] ih_i, iw_i, oh_i, ow_i, in_h, in_w, out_h, out_w;
    logic [3:0]  cons_ack, dim_valid;
    logic [12:0] sub_h, sub_w;
    logic [25:0] in_pixels, out_pixels;

    typedef struct {
        logic [31:0] ih, iw, oh, ow;
        logic [12:0] sh, sw;
        logic [25:0] ip, op;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pp_pipeline_accel_dim_bcast dut (
        .ap_clk         (clk),
        .ap_rst_n       (rst_n),
        .ap_start       (ap_start),
        .ap_ready       (ap_ready),
        .ap_idle        (ap_idle),
        .ap_done        (ap_done),
        .in_img_height  (ih_i),
        .in_img_width   (iw_i),
        .out_img_height (oh_i),
        .out_img_width  (ow_i),
        .cons_ack       (cons_ack),
        .dim_valid      (dim_valid),
        .in_h           (in_h),
        .in_w           (in_w),
        .out_h          (out_h),
        .out_w          (out_w),
        .sub_h          (sub_h),
        .sub_w          (sub_w),
        .in_pixels      (in_pixels),
        .out_pixels     (out_pixels),
        .cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic bad_dim(input logic [31:0] d);
        return (d == 0) || (d > 4096);
    endfunction

    function automatic exp_t model(input logic [31:0] ih, iw, oh, ow);
        exp_t e;
        longint unsigned pi, po;
        e.ih  = ih;
        e.iw  = iw;
        e.oh  = oh;
        e.ow  = ow;
        e.sh  = 13'(ih / 2);
        e.sw  = 13'(iw / 2);
        e.err = bad_dim(ih) || bad_dim(iw) || bad_dim(oh) || bad_dim(ow);
        pi    = longint'(ih) * longint'(iw);
        po    = longint'(oh) * longint'(ow);
        e.ip  = e.err ? 26'd0 : 26'(pi);
        e.op  = e.err ? 26'd0 : 26'(po);
        return e;
    endfunction

    task automatic set_dims(input logic [31:0] ih, iw, oh, ow);
        ih_i = ih;
        iw_i = iw;
        oh_i = oh;
        ow_i = ow;
    endtask

    // Called at a negedge in IDLE; returns at the first negedge after the capture edge.
    task automatic start_frame(input bit hold);
        ap_start = 1'b1;
        #1;
        check_val("ap_ready_capture", ap_ready, 1);
        exp_q.push_back(model(ih_i, iw_i, oh_i, ow_i));
        @(negedge clk);
        if (!hold) ap_start = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        int   s, lat;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", exp_q.size(), 1);
            return;
        end
        lat = exp_q[0].err ? 1 : NB + 1;
        s   = 1;
        while (!ap_done && s < 40) begin
            check_val("no_rearm", ap_ready, 0);
            @(negedge clk);
            s++;
        end
        if (!ap_done) begin
            check_val("done_timeout", ap_done, 1);
            return;
        end
        e = exp_q.pop_front();
        check_val("latency", s, lat);
        check_val("dim_valid_set", dim_valid, 4'hF);
        check_val("in_h", in_h, e.ih);
        check_val("in_w", in_w, e.iw);
        check_val("out_h", out_h, e.oh);
        check_val("out_w", out_w, e.ow);
        check_val("sub_h", sub_h, e.sh);
        check_val("sub_w", sub_w, e.sw);
        check_val("in_pixels", in_pixels, e.ip);
        check_val("out_pixels", out_pixels, e.op);
        check_val("cfg_err", cfg_err, e.err);
    endtask

    task automatic ack_all();
        cons_ack = 4'hF;
        @(negedge clk);
        cons_ack = 4'h0;
        check_val("ack_all_valid", dim_valid, 0);
        check_val("ack_all_done", ap_done, 0);
        check_val("ack_all_idle", ap_idle, !ap_start);
    endtask

    task automatic stagger(input logic [3:0] ack, input logic [3:0] dv, input logic done);
        cons_ack = ack;
        @(negedge clk);
        cons_ack = 4'h0;
        check_val("stagger_valid", dim_valid, dv);
        check_val("stagger_done", ap_done, done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ap_start = 1'b0;
        cons_ack = 4'h0;
        set_dims(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_val("rst_done", ap_done, 0);
        check_val("rst_valid", dim_valid, 0);
        check_val("rst_in_pixels", in_pixels, 0);
        check_val("rst_cfg_err", cfg_err, 0);
        check_val("rst_idle", ap_idle, 1);
        ap_start = 1'b1;
        #1;
        check_val("rst_idle_follows_start", ap_idle, 0);
        check_val("rst_ready", ap_ready, 0);
        ap_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame, input changes during HOLD, staggered acks
        set_dims(1080, 1920, 384, 640);
        start_frame(0);
        wait_done();
        set_dims(7, 7, 7, 7);
        ap_start = 1'b1;
        #1;
        check_val("hold_no_ready", ap_ready, 0);
        @(negedge clk);
        ap_start = 1'b0;
        check_val("hold_in_h", in_h, 1080);
        check_val("hold_sub_w", sub_w, 960);
        check_val("hold_in_pixels", in_pixels, 2073600);
        stagger(4'b0001, 4'b1110, 1);
        stagger(4'b0001, 4'b1110, 1);
        stagger(4'b0100, 4'b1010, 1);
        stagger(4'b0010, 4'b1000, 1);
        stagger(4'b1000, 4'b0000, 0);
        check_val("idle_after_stagger", ap_idle, 1);

        // Zero width error, then a legal odd-width set
        set_dims(720, 0, 480, 640);
        start_frame(0);
        wait_done();
        ack_all();
        set_dims(720, 1281, 480, 640);
        start_frame(0);
        wait_done();
        ack_all();

        // Largest legal and just-over-range
        set_dims(4096, 4096, 4096, 4096);
        start_frame(0);
        wait_done();
        ack_all();
        set_dims(1080, 4097, 384, 640);
        start_frame(0);
        wait_done();
        ack_all();

        // Start held: one ready per frame, recapture in first IDLE cycle
        set_dims(600, 800, 300, 400);
        start_frame(1);
        wait_done();
        cons_ack = 4'hF;
        @(negedge clk);
        cons_ack = 4'h0;
        check_val("held_valid_cleared", dim_valid, 0);
        set_dims(1000, 1001, 17, 33);
        #1;
        check_val("held_rearm_ready", ap_ready, 1);
        exp_q.push_back(model(ih_i, iw_i, oh_i, ow_i));
        @(negedge clk);
        ap_start = 1'b0;
        wait_done();
        ack_all();

        // Reset during CALC
        set_dims(1080, 1920, 384, 640);
        start_frame(0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_in_h", in_h, 0);
        check_val("arst_sub_h", sub_h, 0);
        check_val("arst_done", ap_done, 0);
        check_val("arst_valid", dim_valid, 0);
        check_val("arst_idle", ap_idle, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_dims(200, 300, 100, 150);
        start_frame(0);
        wait_done();
        ack_all();

        check_val("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
